pipe_xform: RTL and testbench

Parametrised successor to the single-bit register/transform pair in the TOP/SUB design. Carries CH independent WIDTH-bit channels through a DEPTH-stage valid/ready register pipeline, applying a selectable per-channel transform at entry. The transform generalises the one-bit conditional-invert function to full words. Adds a programmable mode register with a safe drain-before-switch rule, backpressure, and an occupancy count.

---
 rtl/pipe_xform.sv | 143 ++++++++++++++
 tb/tb_pipe_xform.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_xform.sv
// rtl/pipe_xform.sv - multi-channel word transform feeding a valid/ready register pipeline
//
// Purpose:
//   Carries CH independent WIDTH-bit channels through DEPTH register stages.
//   Each word is transformed once, on acceptance, using the mode in force at
//   that moment. A mode change waits until the pipeline is empty, so words
//   already in flight keep the transform they were accepted with.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-low reset
//   IN_VALID   upstream word valid
//   IN_READY   word accepted this cycle (combinational)
//   IN         input word, channel k at [k*WIDTH +: WIDTH]
//   MODE       requested transform (00 pass, 01 invert, 10 cond-invert, 11 clear)
//   MODE_LOAD  one-cycle strobe requesting MODE
//   OUT_VALID  last stage holds a word
//   OUT_READY  downstream takes OUT this cycle
//   OUT        last stage data
//   COUNT      number of occupied stages
//   MODE_CUR   transform applied to newly accepted words
//   MODE_PEND  a mode change is waiting for the pipeline to drain

module pipe_xform #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CH    = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [CH*WIDTH-1:0]          IN,
    input  logic [1:0]                   MODE,
    input  logic                         MODE_LOAD,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [CH*WIDTH-1:0]          OUT,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic [1:0]                   MODE_CUR,
    output logic                         MODE_PEND
);

    localparam int DW = CH * WIDTH;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q;
    logic [DW-1:0]    d_q [DEPTH];
    logic [DEPTH-1:0] leave;
    logic [DW-1:0]    xin;
    logic             accept;
    logic             drain;
    logic [CW-1:0]    count_q;
    logic [1:0]       mode_cur_q;
    logic [1:0]       pend_val_q;
    logic             pend_q;

    function automatic logic [WIDTH-1:0] xform(input logic [1:0] m, input logic [WIDTH-1:0] x);
        case (m)
            2'b00:   return x;
            2'b01:   return ~x;
            2'b10:   return x[WIDTH-1] ? ~x : x;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        xin = '0;
        for (int k = 0; k < CH; k++) begin
            xin[k*WIDTH +: WIDTH] = xform(mode_cur_q, IN[k*WIDTH +: WIDTH]);
        end
    end

    // leave[i]: stage i hands its word onward this cycle. Evaluated from the
    // output end backwards so a full pipeline can still move when OUT drains,
    // and a bubble downstream lets everything behind it close up.
    always_comb begin
        logic carry;
        leave = '0;
        carry = v_q[DEPTH-1] && OUT_READY;
        leave[DEPTH-1] = carry;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            carry    = v_q[i] && (!v_q[i+1] || carry);
            leave[i] = carry;
        end
    end

    assign drain = leave[DEPTH-1];

    // MODE_LOAD also blocks entry so a load into an idle pipeline never
    // lets a word slip in under the outgoing mode.
    assign IN_READY = RST && !pend_q && !MODE_LOAD && (!v_q[0] || leave[0]);
    assign accept   = IN_VALID && IN_READY;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            v_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
            count_q    <= '0;
            mode_cur_q <= 2'b00;
            pend_val_q <= 2'b00;
            pend_q     <= 1'b0;
        end else begin
            if (accept) begin
                d_q[0] <= xin;
                v_q[0] <= 1'b1;
            end else if (leave[0]) begin
                v_q[0] <= 1'b0;
            end

            // Stage i loads exactly when stage i-1 leaves.
            for (int i = 1; i < DEPTH; i++) begin
                if (leave[i-1]) begin
                    d_q[i] <= d_q[i-1];
                    v_q[i] <= 1'b1;
                end else if (leave[i]) begin
                    v_q[i] <= 1'b0;
                end
            end

            count_q <= count_q + CW'(accept) - CW'(drain);

            // A load arriving in the switch cycle is folded into the switch
            // so the most recent request is the one applied.
            if (pend_q && (count_q == '0)) begin
                mode_cur_q <= MODE_LOAD ? MODE : pend_val_q;
                pend_q     <= 1'b0;
            end else if (MODE_LOAD) begin
                pend_val_q <= MODE;
                pend_q     <= 1'b1;
            end
        end
    end

    assign OUT_VALID = v_q[DEPTH-1];
    assign OUT       = d_q[DEPTH-1];
    assign COUNT     = count_q;
    assign MODE_CUR  = mode_cur_q;
    assign MODE_PEND = pend_q;

endmodule

// File: tb/tb_pipe_xform.sv
// tb/tb_pipe_xform.sv - directed and scoreboard bench for pipe_xform

module tb_pipe_xform;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] IN;
    logic [1:0]  MODE;
    logic        MODE_LOAD;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] OUT;
    logic [1:0]  COUNT;
    logic [1:0]  MODE_CUR;
    logic        MODE_PEND;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] acc_q[$];
    logic [15:0] out_q[$];

    pipe_xform #(.WIDTH(8), .DEPTH(2), .CH(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN        (IN),
        .MODE      (MODE),
        .MODE_LOAD (MODE_LOAD),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT       (OUT),
        .COUNT     (COUNT),
        .MODE_CUR  (MODE_CUR),
        .MODE_PEND (MODE_PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Records both transfers of the current cycle, then moves past one rising edge.
    task automatic step();
        #1;
        if (IN_VALID && IN_READY) acc_q.push_back(IN);
        if (OUT_VALID && OUT_READY) out_q.push_back(OUT);
        @(negedge CLK);
    endtask

    task automatic set_mode(input logic [1:0] m);
        MODE = m;
        MODE_LOAD = 1'b1;
        IN_VALID = 1'b0;
        step();
        MODE_LOAD = 1'b0;
        for (int k = 0; k < 10 && MODE_PEND === 1'b1; k++) step();
    endtask

    task automatic send_get(input logic [15:0] w, output logic [15:0] got, output bit seen);
        IN = w;
        IN_VALID = 1'b1;
        OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        seen = 1'b0;
        got = '0;
        for (int k = 0; k < 10; k++) begin
            if (OUT_VALID === 1'b1) begin
                got = OUT;
                seen = 1'b1;
                step();
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        acc_q.delete(); out_q.delete();
        RST = 1'b0; IN_VALID = 1'b1; IN = 16'hFFFF; OUT_READY = 1'b1; MODE_LOAD = 1'b0; MODE = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready c=%0d: got %b want 0", c, IN_READY); end
            step();
        end
        #1;
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
        n_cmp++; if (OUT !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", OUT); end
        n_cmp++; if (COUNT !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", COUNT); end
        n_cmp++; if (MODE_CUR !== 2'b00) begin n_bad++; $display("FAIL reset_mode_cur: got %b want 00", MODE_CUR); end
        n_cmp++; if (MODE_PEND !== 1'b0) begin n_bad++; $display("FAIL reset_mode_pend: got %b want 0", MODE_PEND); end
        RST = 1'b1; IN_VALID = 1'b0;
        for (int c = 0; c < 4; c++) step();
        n_cmp++; if (out_q.size() != 0) begin n_bad++; $display("FAIL reset_nothing_out: got %0d words want 0", out_q.size()); end
    endtask

    task automatic test_streaming();
        logic [15:0] w [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        acc_q.delete(); out_q.delete();
        OUT_READY = 1'b1;
        for (int c = 0; c < 7; c++) begin
            IN_VALID = (c < 4);
            IN = (c < 4) ? w[c] : 16'h0000;
            #1;
            if (c < 4) begin
                n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, IN_READY); end
            end
            if (c >= 2 && c < 6) begin
                n_cmp++; if (OUT_VALID !== 1'b1 || OUT !== w[c-2]) begin n_bad++; $display("FAIL stream_out c=%0d: got v=%b %h want v=1 %h", c, OUT_VALID, OUT, w[c-2]); end
            end else begin
                n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL stream_idle c=%0d: got v=%b want 0", c, OUT_VALID); end
            end
            step();
        end
    endtask

    task automatic test_transforms();
        logic [1:0]  modes [3] = '{2'b01, 2'b10, 2'b11};
        logic [15:0] ins   [3] = '{16'h00F0, 16'h8005, 16'hABCD};
        logic [15:0] exps  [3] = '{16'hFF0F, 16'h7F05, 16'h0000};
        logic [15:0] got;
        bit seen;
        for (int t = 0; t < 3; t++) begin
            set_mode(modes[t]);
            n_cmp++; if (MODE_CUR !== modes[t] || MODE_PEND !== 1'b0) begin n_bad++; $display("FAIL xform_mode_set t=%0d: got cur=%b pend=%b want cur=%b pend=0", t, MODE_CUR, MODE_PEND, modes[t]); end
            send_get(ins[t], got, seen);
            n_cmp++; if (!seen || got !== exps[t]) begin n_bad++; $display("FAIL xform_out mode=%b: got seen=%0d %h want %h", modes[t], seen, got, exps[t]); end
        end
        set_mode(2'b00);
        n_cmp++; if (MODE_CUR !== 2'b00) begin n_bad++; $display("FAIL xform_restore: got %b want 00", MODE_CUR); end
    endtask

    task automatic test_backpressure();
        acc_q.delete(); out_q.delete();
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            IN = 16'(acc_q.size() + 1);
            #1;
            if (c >= 2) begin
                n_cmp++; if (COUNT !== 2'd2) begin n_bad++; $display("FAIL bp_count c=%0d: got %0d want 2", c, COUNT); end
                n_cmp++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, IN_READY); end
            end
            step();
        end
        OUT_READY = 1'b1;
        for (int c = 0; c < 60 && out_q.size() < 20; c++) begin
            IN = 16'(acc_q.size() + 1);
            IN_VALID = (acc_q.size() < 20);
            #1;
            if (c == 0) begin
                n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL bp_full_release_ready: got %b want 1", IN_READY); end
            end
            step();
        end
        IN_VALID = 1'b0;
        n_cmp++; if (out_q.size() != 20) begin n_bad++; $display("FAIL bp_out_count: got %0d want 20", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 20; i++) begin
            n_cmp++; if (out_q[i] !== 16'(i + 1)) begin n_bad++; $display("FAIL bp_order i=%0d: got %h want %h", i, out_q[i], 16'(i + 1)); end
        end
    endtask

    task automatic test_random();
        acc_q.delete(); out_q.delete();
        for (int c = 0; c < 4000 && out_q.size() < 200; c++) begin
            IN_VALID = (acc_q.size() < 200) && ($urandom_range(0, 3) != 0);
            IN = 16'($urandom);
            OUT_READY = $urandom_range(0, 1) != 0;
            #1;
            n_cmp++; if (COUNT !== 2'(acc_q.size() - out_q.size())) begin n_bad++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, COUNT, acc_q.size() - out_q.size()); end
            step();
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        n_cmp++; if (out_q.size() != 200) begin n_bad++; $display("FAIL rand_out_count: got %0d want 200", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < acc_q.size(); i++) begin
            n_cmp++; if (out_q[i] !== acc_q[i]) begin n_bad++; $display("FAIL rand_scoreboard i=%0d: got %h want %h", i, out_q[i], acc_q[i]); end
        end
    endtask

    task automatic test_mode_switch();
        acc_q.delete(); out_q.delete();
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        IN = 16'h1111; step();
        IN = 16'h2222; step();
        MODE = 2'b01; MODE_LOAD = 1'b1; IN = 16'h0F0F;
        #1;
        n_cmp++; if (IN_READY !== 1'b0 || COUNT !== 2'd2) begin n_bad++; $display("FAIL ms_load_cycle: got rdy=%b cnt=%0d want rdy=0 cnt=2", IN_READY, COUNT); end
        step();
        MODE_LOAD = 1'b0;
        #1;
        n_cmp++; if (MODE_PEND !== 1'b1 || IN_READY !== 1'b0) begin n_bad++; $display("FAIL ms_hold: got pend=%b rdy=%b want pend=1 rdy=0", MODE_PEND, IN_READY); end
        step();
        OUT_READY = 1'b1;
        #1;
        n_cmp++; if (IN_READY !== 1'b0 || MODE_PEND !== 1'b1 || COUNT !== 2'd2) begin n_bad++; $display("FAIL ms_drain_a: got rdy=%b pend=%b cnt=%0d want 0 1 2", IN_READY, MODE_PEND, COUNT); end
        step();
        #1;
        n_cmp++; if (IN_READY !== 1'b0 || COUNT !== 2'd1) begin n_bad++; $display("FAIL ms_drain_b: got rdy=%b cnt=%0d want 0 1", IN_READY, COUNT); end
        step();
        #1;
        n_cmp++; if (COUNT !== 2'd0 || MODE_PEND !== 1'b1 || MODE_CUR !== 2'b00 || IN_READY !== 1'b0) begin n_bad++; $display("FAIL ms_switch_cycle: got cnt=%0d pend=%b cur=%b rdy=%b want 0 1 00 0", COUNT, MODE_PEND, MODE_CUR, IN_READY); end
        step();
        #1;
        n_cmp++; if (MODE_CUR !== 2'b01 || MODE_PEND !== 1'b0 || IN_READY !== 1'b1) begin n_bad++; $display("FAIL ms_after_switch: got cur=%b pend=%b rdy=%b want 01 0 1", MODE_CUR, MODE_PEND, IN_READY); end
        step();
        IN_VALID = 1'b0;
        for (int k = 0; k < 6; k++) step();
        n_cmp++; if (out_q.size() != 3) begin n_bad++; $display("FAIL ms_out_count: got %0d want 3", out_q.size()); end
        if (out_q.size() == 3) begin
            n_cmp++; if (out_q[0] !== 16'h1111) begin n_bad++; $display("FAIL ms_word0: got %h want 1111", out_q[0]); end
            n_cmp++; if (out_q[1] !== 16'h2222) begin n_bad++; $display("FAIL ms_word1: got %h want 2222", out_q[1]); end
            n_cmp++; if (out_q[2] !== 16'hF0F0) begin n_bad++; $display("FAIL ms_word2: got %h want F0F0", out_q[2]); end
        end
    endtask

    task automatic test_reset_mid();
        acc_q.delete(); out_q.delete();
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        IN = 16'hAAAA; step();
        IN = 16'hBBBB; step();
        IN_VALID = 1'b0; MODE = 2'b10; MODE_LOAD = 1'b1; step();
        MODE_LOAD = 1'b0;
        #1;
        n_cmp++; if (COUNT !== 2'd2 || MODE_PEND !== 1'b1) begin n_bad++; $display("FAIL rm_setup: got cnt=%0d pend=%b want 2 1", COUNT, MODE_PEND); end
        RST = 1'b0;
        step();
        RST = 1'b1;
        #1;
        n_cmp++; if (COUNT !== 2'd0) begin n_bad++; $display("FAIL rm_count: got %0d want 0", COUNT); end
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL rm_out_valid: got %b want 0", OUT_VALID); end
        n_cmp++; if (MODE_PEND !== 1'b0 || MODE_CUR !== 2'b00) begin n_bad++; $display("FAIL rm_mode: got pend=%b cur=%b want 0 00", MODE_PEND, MODE_CUR); end
        OUT_READY = 1'b1;
        for (int k = 0; k < 6; k++) step();
        n_cmp++; if (out_q.size() != 0) begin n_bad++; $display("FAIL rm_dropped: got %0d words want 0", out_q.size()); end
    endtask

    initial begin
        RST = 1'b0; IN_VALID = 1'b0; IN = '0; MODE = 2'b00; MODE_LOAD = 1'b0; OUT_READY = 1'b1;
        @(negedge CLK);
        test_reset();
        test_streaming();
        test_transforms();
        test_backpressure();
        test_random();
        test_mode_switch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
